// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constant helpers for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bit time in clock cycles; integer truncation of the ratio.
  function automatic int calc_div(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

  // Smallest counter width that can hold div-1 (at least one bit).
  function automatic int calc_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word fall-through read port
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered 8N1 serial transmitter
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUDRATE = 9600,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] data_i,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);

  localparam int DIV = calc_div(CLK_FREQ, BAUDRATE);
  localparam int CW  = calc_cnt_width(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic [AW:0]   count;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bit_end;

  assign push    = wr_en && !rst;
  assign bit_end = (cnt == LAST_CNT);
  assign busy    = (state != IDLE) || (count != '0);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(data_i),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and pop decision; STOP chains straight into START when data is waiting.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end && (idx == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit timer, bit index and shift register; the timer restarts at every bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (pop) shift <= head;
      if ((state == IDLE) || bit_end) cnt <= '0;
      else                            cnt <= cnt + CNT_ONE;
      if (state != DATA) idx <= '0;
      else if (bit_end)  idx <= idx + 3'd1;
    end
  end

  // Line driver registered from the current state, so tx lags the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[idx];
        default: tx <= 1'b1;
      endcase
    end
  end

  // Dropped-write flag, high for the single cycle after the rejected write.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= wr_en && full;
  end

endmodule
